// File: rtl/mcu_ctrl_pkg.sv
// Shared encodings for the MCU control FSM: states, opcodes, bus2 sources, decoded classes.
package mcu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_FET1 = 4'd1,
        ST_FET2 = 4'd2,
        ST_DEC  = 4'd3,
        ST_EX   = 4'd4,
        ST_MEM  = 4'd5,
        ST_IRQ  = 4'd6,
        ST_HALT = 4'd7
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_LDI  = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_JNZ  = 4'd10;
    localparam logic [3:0] OP_NOP  = 4'd11;
    localparam logic [3:0] OP_RETI = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] B2_ALU   = 3'd0;
    localparam logic [2:0] B2_BUS1A = 3'd1;
    localparam logic [2:0] B2_MEM   = 3'd2;
    localparam logic [2:0] B2_ADDR  = 3'd3;
    localparam logic [2:0] B2_IMM   = 3'd4;

    typedef enum logic [3:0] {
        CL_ALU, CL_NOT, CL_LDI, CL_LD, CL_ST, CL_JMP, CL_JZ, CL_JNZ,
        CL_NOP, CL_RETI, CL_HALT, CL_ILL
    } op_class_t;

endpackage

// File: rtl/mcu_ctrl_decode.sv
// Opcode-to-class decoder; RETI is legal only when MCU_CTRL_IRQ_EN is defined.
module mcu_ctrl_decode
    import mcu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] op_class
);

    always_comb begin
        op_class = CL_ILL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CL_ALU;
            OP_NOT:  op_class = CL_NOT;
            OP_LDI:  op_class = CL_LDI;
            OP_LD:   op_class = CL_LD;
            OP_ST:   op_class = CL_ST;
            OP_JMP:  op_class = CL_JMP;
            OP_JZ:   op_class = CL_JZ;
            OP_JNZ:  op_class = CL_JNZ;
            OP_NOP:  op_class = CL_NOP;
            OP_HALT: op_class = CL_HALT;
`ifdef MCU_CTRL_IRQ_EN
            OP_RETI: op_class = CL_RETI;
`endif
            default: op_class = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mcu_ctrl_fsm.sv
// Multi-cycle MCU control FSM with combinational strobes from state and IR.
// Optional interrupt support is enabled with `define MCU_CTRL_IRQ_EN.
module mcu_ctrl_fsm
    import mcu_ctrl_pkg::*;
#(
    parameter int WORD_W  = 14,
    parameter int NREG    = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int IRQ_VEC = 'h40,
    localparam int RSEL_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] instruction,
    input  logic              zero,
    input  logic              mem_ack,
`ifdef MCU_CTRL_IRQ_EN
    input  logic              irq,
    output logic              irq_ack,
`endif
    output logic [RSEL_W-1:0] sel_a,
    output logic [RSEL_W-1:0] sel_b,
    output logic [2:0]        bus2_sel,
    output logic [NREG-1:0]   reg_load,
    output logic              load_pc,
    output logic              inc_pc,
    output logic              load_ir,
    output logic              load_addr,
    output logic              load_z,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] addr_field,
    output logic [DATA_W-1:0] imm_field,
    output logic [3:0]        state,
    output logic              halted,
    output logic              illegal
);

    state_t      state_q;
    state_t      resume;
    op_class_t   cls;
    logic [3:0]  cls_raw;
    logic        illegal_q;

    logic [3:0]        opcode;
    logic [RSEL_W-1:0] src_a, src_b, dest, rfld;

    assign opcode = instruction[WORD_W-1 -: 4];
    assign src_a  = instruction[3*RSEL_W-1 -: RSEL_W];
    assign src_b  = instruction[2*RSEL_W-1 -: RSEL_W];
    assign dest   = instruction[RSEL_W-1:0];
    assign rfld   = instruction[ADDR_W+RSEL_W-1 -: RSEL_W];

    mcu_ctrl_decode u_decode (
        .opcode   (opcode),
        .op_class (cls_raw)
    );
    assign cls = op_class_t'(cls_raw);

`ifdef MCU_CTRL_IRQ_EN
    logic              ie_q;
    logic [ADDR_W-1:0] shadow_q;
    logic [ADDR_W-1:0] pc_q;
    assign resume = (irq && ie_q) ? ST_IRQ : ST_FET1;
`else
    assign resume = ST_FET1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
`ifdef MCU_CTRL_IRQ_EN
            ie_q      <= 1'b1;
            shadow_q  <= '0;
            pc_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_q <= ST_FET1;
                ST_FET1: state_q <= ST_FET2;
                ST_FET2: if (mem_ack) state_q <= ST_DEC;
                ST_DEC: begin
                    case (cls)
                        CL_ALU:        state_q <= ST_EX;
                        CL_LD, CL_ST:  state_q <= ST_MEM;
                        CL_HALT:       state_q <= ST_HALT;
                        CL_ILL: begin
                            illegal_q <= 1'b1;
                            state_q   <= ST_HALT;
                        end
                        default:       state_q <= resume;
                    endcase
                end
                ST_EX:   state_q <= resume;
                ST_MEM:  if (mem_ack) state_q <= resume;
                ST_IRQ:  state_q <= ST_FET1;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
`ifdef MCU_CTRL_IRQ_EN
            // pc_q mirrors the datapath PC from our own load/increment strobes
            if (load_pc)
                pc_q <= addr_field;
            else if (inc_pc)
                pc_q <= pc_q + ADDR_W'(1);
            if (state_q == ST_IRQ) begin
                ie_q     <= 1'b0;
                shadow_q <= pc_q;
            end else if (state_q == ST_DEC && cls == CL_RETI) begin
                ie_q     <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        bus2_sel   = B2_ALU;
        reg_load   = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_addr  = 1'b0;
        load_z     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_field = instruction[ADDR_W-1:0];
`ifdef MCU_CTRL_IRQ_EN
        irq_ack    = 1'b0;
`endif
        case (state_q)
            ST_FET1: begin
                bus2_sel  = B2_BUS1A;
                load_addr = 1'b1;
            end
            ST_FET2: begin
                mem_req  = 1'b1;
                bus2_sel = B2_MEM;
                load_ir  = mem_ack;
                inc_pc   = mem_ack;
            end
            ST_DEC: begin
                case (cls)
                    CL_ALU: begin
                        sel_a = src_a;
                        sel_b = src_b;
                    end
                    CL_NOT: begin
                        sel_a          = src_a;
                        bus2_sel       = B2_ALU;
                        load_z         = 1'b1;
                        reg_load[dest] = 1'b1;
                    end
                    CL_LDI: begin
                        bus2_sel       = B2_IMM;
                        reg_load[rfld] = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        bus2_sel  = B2_ADDR;
                        load_addr = 1'b1;
                    end
                    CL_JMP: begin
                        bus2_sel = B2_ADDR;
                        load_pc  = 1'b1;
                    end
                    CL_JZ: begin
                        bus2_sel = B2_ADDR;
                        load_pc  = zero;
                    end
                    CL_JNZ: begin
                        bus2_sel = B2_ADDR;
                        load_pc  = ~zero;
                    end
`ifdef MCU_CTRL_IRQ_EN
                    CL_RETI: begin
                        bus2_sel   = B2_ADDR;
                        addr_field = shadow_q;
                        load_pc    = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            ST_EX: begin
                sel_a          = src_a;
                sel_b          = src_b;
                bus2_sel       = B2_ALU;
                load_z         = 1'b1;
                reg_load[dest] = 1'b1;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (cls == CL_ST) begin
                    mem_we = 1'b1;
                    sel_a  = rfld;
                end else begin
                    bus2_sel       = B2_MEM;
                    reg_load[rfld] = mem_ack;
                end
            end
`ifdef MCU_CTRL_IRQ_EN
            ST_IRQ: begin
                irq_ack    = 1'b1;
                bus2_sel   = B2_ADDR;
                addr_field = ADDR_W'(IRQ_VEC);
                load_pc    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign imm_field = instruction[DATA_W-1:0];
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_mcu_ctrl_fsm.sv
// Directed self-checking bench for mcu_ctrl_fsm; adds interrupt checks when MCU_CTRL_IRQ_EN is defined.
module tb_mcu_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] instruction;
    logic        zero;
    logic        mem_ack;
    logic [1:0]  sel_a, sel_b;
    logic [2:0]  bus2_sel;
    logic [3:0]  reg_load;
    logic        load_pc, inc_pc, load_ir, load_addr, load_z, mem_req, mem_we;
    logic [7:0]  addr_field, imm_field;
    logic [3:0]  state;
    logic        halted, illegal;
`ifdef MCU_CTRL_IRQ_EN
    logic        irq, irq_ack;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mcu_ctrl_fsm #(
        .WORD_W  (14),
        .NREG    (4),
        .ADDR_W  (8),
        .DATA_W  (8),
        .IRQ_VEC ('h40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instruction (instruction),
        .zero        (zero),
        .mem_ack     (mem_ack),
`ifdef MCU_CTRL_IRQ_EN
        .irq         (irq),
        .irq_ack     (irq_ack),
`endif
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .bus2_sel    (bus2_sel),
        .reg_load    (reg_load),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .load_addr   (load_addr),
        .load_z      (load_z),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_field  (addr_field),
        .imm_field   (imm_field),
        .state       (state),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects FET1; fetches instr with an immediate ack and stops in DEC.
    task automatic run_to_dec(input logic [13:0] instr);
        instruction = instr;
        mem_ack     = 1'b1;
        tick();
        tick();
    endtask

    task automatic restart();
        rst = 1'b0;
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; instruction = '0; zero = 1'b0; mem_ack = 1'b1;
`ifdef MCU_CTRL_IRQ_EN
        irq = 1'b0;
`endif
        tick();
        tick();
        check("rst_state",   32'(state),    0);
        check("rst_mem_req", 32'(mem_req),  0);
        check("rst_regload", 32'(reg_load), 0);
        check("rst_illegal", 32'(illegal),  0);
        check("rst_halted",  32'(halted),   0);

        // ADD R1,R2 -> R3
        rst = 1'b1;
        tick();
        check("idle_hold", 32'(state), 0);
        start = 1'b1;
        instruction = 14'h001B;
        tick();
        check("add_fet1",      32'(state),     1);
        check("add_fet1_b2",   32'(bus2_sel),  1);
        check("add_fet1_ladr", 32'(load_addr), 1);
        tick();
        check("add_fet2",      32'(state),   2);
        check("add_fet2_req",  32'(mem_req), 1);
        check("add_fet2_ir",   32'(load_ir), 1);
        check("add_fet2_inc",  32'(inc_pc),  1);
        tick();
        check("add_dec",       32'(state), 3);
        check("add_dec_sela",  32'(sel_a), 1);
        check("add_dec_selb",  32'(sel_b), 2);
        tick();
        check("add_ex",        32'(state),    4);
        check("add_ex_rl",     32'(reg_load), 4'b1000);
        check("add_ex_z",      32'(load_z),   1);
        check("add_ex_b2",     32'(bus2_sel), 0);
        tick();
        check("add_back_fet1", 32'(state), 1);
        start = 1'b0;

        // LDI R2,#0x5A
        run_to_dec(14'h165A);
        check("ldi_b2",  32'(bus2_sel),  4);
        check("ldi_rl",  32'(reg_load),  4'b0100);
        check("ldi_imm", 32'(imm_field), 8'h5A);
        tick();
        check("ldi_next", 32'(state), 1);

        // NOT R1 -> R2, written in DEC
        run_to_dec(14'h1012);
        check("not_rl",  32'(reg_load), 4'b0100);
        check("not_z",   32'(load_z),   1);
        check("not_sel", 32'(sel_a),    1);
        tick();
        check("not_next", 32'(state), 1);

        // LD R2,0x25 with ack after 3 wait cycles
        run_to_dec(14'h1A25);
        check("ld_dec_b2",   32'(bus2_sel),   3);
        check("ld_dec_ladr", 32'(load_addr),  1);
        check("ld_dec_addr", 32'(addr_field), 8'h25);
        mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            check("ld_mem_state", 32'(state),    5);
            check("ld_mem_req",   32'(mem_req),  1);
            check("ld_mem_rl",    32'(reg_load), (i == 3) ? 4'b0100 : 4'b0000);
            tick();
        end
        check("ld_next", 32'(state),   1);
        check("ld_drop", 32'(mem_req), 0);

        // ST R1,0x30
        run_to_dec(14'h1D30);
        tick();
        check("st_mem_we",  32'(mem_we),   1);
        check("st_mem_sel", 32'(sel_a),    1);
        check("st_mem_rl",  32'(reg_load), 0);
        tick();
        check("st_next", 32'(state), 1);

        // Conditional and unconditional jumps
        zero = 1'b0;
        run_to_dec(14'h2410);
        check("jz_z0", 32'(load_pc), 0);
        tick();
        zero = 1'b1;
        run_to_dec(14'h2410);
        check("jz_z1", 32'(load_pc), 1);
        tick();
        run_to_dec(14'h2810);
        check("jnz_z1", 32'(load_pc), 0);
        tick();
        zero = 1'b0;
        run_to_dec(14'h2810);
        check("jnz_z0", 32'(load_pc), 1);
        tick();
        run_to_dec(14'h2033);
        check("jmp_pc",   32'(load_pc),    1);
        check("jmp_b2",   32'(bus2_sel),   3);
        check("jmp_addr", 32'(addr_field), 8'h33);
        tick();
        check("jmp_next", 32'(state), 1);

        // Illegal opcode 13 -> sticky HALT
        run_to_dec(14'h3400);
        tick();
        check("ill_state",  32'(state),   7);
        check("ill_flag",   32'(illegal), 1);
        check("ill_halted", 32'(halted),  1);
        start = 1'b1;
        repeat (20) tick();
        check("ill_hold_state", 32'(state),   7);
        check("ill_hold_flag",  32'(illegal), 1);
        start = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("ill_async_clr",   32'(illegal), 0);
        check("ill_async_state", 32'(state),   0);
        tick();
        rst = 1'b1;

        // Reset during the FET2 wait
        start = 1'b1;
        tick();
        start   = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        tick();
        check("wait_state", 32'(state),   2);
        check("wait_req",   32'(mem_req), 1);
        check("wait_ir",    32'(load_ir), 0);
        #2;
        rst = 1'b0;
        #1;
        check("wait_rst_req",   32'(mem_req), 0);
        check("wait_rst_state", 32'(state),   0);
        tick();

        // HALT opcode: halted without illegal
        restart();
        check("halt_fet1", 32'(state), 1);
        run_to_dec(14'h3C00);
        tick();
        check("halt_state",   32'(state),   7);
        check("halt_illegal", 32'(illegal), 0);
        check("halt_halted",  32'(halted),  1);

`ifdef MCU_CTRL_IRQ_EN
        // IRQ taken after ADD, then RETI restores PC=1 and re-enables ie
        restart();
        run_to_dec(14'h001B);
        tick();
        irq = 1'b1;
        #1;
        check("irq_ex", 32'(state), 4);
        tick();
        check("irq_state", 32'(state),      6);
        check("irq_ack",   32'(irq_ack),    1);
        check("irq_pc",    32'(load_pc),    1);
        check("irq_vec",   32'(addr_field), 8'h40);
        check("irq_b2",    32'(bus2_sel),   3);
        tick();
        check("irq_fet1", 32'(state), 1);
        run_to_dec(14'h3000);
        check("reti_pc",    32'(load_pc),    1);
        check("reti_addr",  32'(addr_field), 8'h01);
        check("reti_legal", 32'(illegal),    0);
        tick();
        check("reti_masked", 32'(state), 1);
        run_to_dec(14'h2C00);
        tick();
        check("ie_restored", 32'(state), 6);
        irq = 1'b0;
        tick();
        check("irq_done", 32'(state), 1);
`else
        // RETI without interrupt support is illegal
        restart();
        run_to_dec(14'h3000);
        tick();
        check("reti_illegal", 32'(illegal), 1);
        check("reti_halt",    32'(state),   7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
